// File: rtl/grf_wb_arbiter_pkg.sv
// Shared widths, grant-source encoding and the buffered write-back entry type.
package grf_wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    // Which writer owns the GRF write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MDU  = 2'd2
    } gnt_src_t;

    // One buffered MDU result: destination register and data.
    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/grf_wb_arbiter_fifo.sv
// Circular buffer for MDU results; pointers carry one extra wrap bit so
// full and empty can be told apart without a separate count.
module wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    // Pointer advance; the caller never pushes when full nor pops when empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage; stale contents are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the W stage and buffered MDU
// results, tracks registers with an MDU write in flight, and stalls D on hazards.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_RegWrite,
    input  logic [REG_W-1:0]  W_A3,
    input  logic [DATA_W-1:0] W_WD,
    input  logic              mdu_issue,
    input  logic [REG_W-1:0]  mdu_A3,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [REG_W-1:0]  mdu_res_A3,
    input  logic [DATA_W-1:0] mdu_res_WD,
    input  logic [REG_W-1:0]  D_rs,
    input  logic [REG_W-1:0]  D_rt,
    input  logic [REG_W-1:0]  D_A3,
    input  logic              D_RegWrite,
    output logic              D_stall,
    output logic              pipe_hold,
    output logic              G_we,
    output logic [REG_W-1:0]  G_A3,
    output logic [DATA_W-1:0] G_WD
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [OW-1:0] OUT_LIM    = OW'(DEPTH);

    logic             full;
    logic             empty;
    logic             head_valid;
    logic             push;
    logic             pop;
    wb_entry_t        head;
    wb_entry_t        push_data;
    gnt_src_t         gnt;
    logic             issue_ok;
    logic             rs_hazard;
    logic             rt_hazard;
    logic             waw_hazard;
    logic             full_hazard;
    logic [SW-1:0]    starve_cnt;
    logic [OW-1:0]    outstanding;
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;

    assign push_data  = '{a3: mdu_res_A3, wd: mdu_res_WD};
    assign mdu_ready  = ~full;
    assign push       = mdu_valid & ~full;
    assign head_valid = ~empty;
    assign pop        = (gnt == GNT_MDU);
    assign pipe_hold  = head_valid && (starve_cnt == STARVE_LIM);
    assign issue_ok   = mdu_issue & ~D_stall;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // Write-port grant: a starved FIFO head wins, otherwise the pipeline has priority.
    always_comb begin
        gnt  = GNT_NONE;
        G_A3 = '0;
        G_WD = '0;
        if (pipe_hold)       gnt = GNT_MDU;
        else if (W_RegWrite) gnt = GNT_PIPE;
        else if (head_valid) gnt = GNT_MDU;
        case (gnt)
            GNT_PIPE: begin
                G_A3 = W_A3;
                G_WD = W_WD;
            end
            GNT_MDU: begin
                G_A3 = head.a3;
                G_WD = head.wd;
            end
            default: ;
        endcase
        G_we = (gnt != GNT_NONE) && (G_A3 != '0);
    end

    // D-stage hazards; a source being written by the head this cycle is bypassed in GRF.
    always_comb begin
        rs_hazard   = pending[D_rs] && !(pop && (head.a3 == D_rs));
        rt_hazard   = pending[D_rt] && !(pop && (head.a3 == D_rt));
        waw_hazard  = D_RegWrite && pending[D_A3];
        full_hazard = mdu_issue && (outstanding == OUT_LIM);
        D_stall     = rs_hazard | rt_hazard | waw_hazard | full_hazard | pipe_hold;
    end

    // Scoreboard update: a same-cycle set beats the clear, $0 is never pending.
    always_comb begin
        pending_nxt = pending;
        if (pop)      pending_nxt[head.a3] = 1'b0;
        if (issue_ok) pending_nxt[mdu_A3]  = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!reset) pending <= '0;
        else        pending <= pending_nxt;
    end

    // Starvation counter for the FIFO head, saturating at the hold threshold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!head_valid || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Outstanding MDU writes: issued and not yet retired through the FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            outstanding <= '0;
        end else begin
            case ({issue_ok, pop})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_grf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SM    = 4;

    logic        clk;
    logic        reset;
    logic        W_RegWrite;
    logic [4:0]  W_A3;
    logic [31:0] W_WD;
    logic        mdu_issue;
    logic [4:0]  mdu_A3;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_res_A3;
    logic [31:0] mdu_res_WD;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [4:0]  D_A3;
    logic        D_RegWrite;
    logic        D_stall;
    logic        pipe_hold;
    logic        G_we;
    logic [4:0]  G_A3;
    logic [31:0] G_WD;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          q_a3[$];
    logic [31:0] q_wd[$];
    int          inflight[$];
    bit   [31:0] pend;
    int          outst;
    int          starve;

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk        (clk),
        .reset      (reset),
        .W_RegWrite (W_RegWrite),
        .W_A3       (W_A3),
        .W_WD       (W_WD),
        .mdu_issue  (mdu_issue),
        .mdu_A3     (mdu_A3),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_res_A3 (mdu_res_A3),
        .mdu_res_WD (mdu_res_WD),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_A3       (D_A3),
        .D_RegWrite (D_RegWrite),
        .D_stall    (D_stall),
        .pipe_hold  (pipe_hold),
        .G_we       (G_we),
        .G_A3       (G_A3),
        .G_WD       (G_WD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        W_RegWrite = 0; W_A3 = 0; W_WD = 0;
        mdu_issue = 0; mdu_A3 = 0;
        mdu_valid = 0; mdu_res_A3 = 0; mdu_res_WD = 0;
        D_rs = 0; D_rt = 0; D_A3 = 0; D_RegWrite = 0;
    endtask

    task automatic test_reset();
        int stalls;
        idle();
        reset = 0; W_RegWrite = 1; W_A3 = 5; W_WD = 32'h0000_0055;
        step(); step();
        reset = 1;
        settle();
        n_cmp++; if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", mdu_ready); end
        n_cmp++; if (D_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b want 0", D_stall); end
        n_cmp++; if (pipe_hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %0b want 0", pipe_hold); end
        n_cmp++; if (G_we !== 1'b1) begin n_bad++; $display("FAIL reset_we: got %0b want 1", G_we); end
        n_cmp++; if (G_A3 !== 5'd5) begin n_bad++; $display("FAIL reset_a3: got %0d want 5", G_A3); end
        n_cmp++; if (G_WD !== 32'h55) begin n_bad++; $display("FAIL reset_wd: got %h want 55", G_WD); end
        stalls = 0;
        for (int r = 0; r < 32; r++) begin
            D_rs = 5'(r); D_A3 = 5'(r); D_RegWrite = 1;
            #1;
            if (D_stall !== 1'b0) stalls++;
        end
        n_cmp++; if (stalls != 0) begin n_bad++; $display("FAIL reset_scoreboard: %0d regs stalled want 0", stalls); end
        idle();
        step();
    endtask

    task automatic test_issue_stall();
        idle();
        mdu_issue = 1; mdu_A3 = 8;
        settle();
        n_cmp++; if (D_stall !== 1'b0) begin n_bad++; $display("FAIL issue_accept_stall: got %0b want 0", D_stall); end
        step();
        mdu_issue = 0; D_rs = 8;
        settle();
        n_cmp++; if (D_stall !== 1'b1) begin n_bad++; $display("FAIL issue_raw_stall: got %0b want 1", D_stall); end
        step();
        mdu_valid = 1; mdu_res_A3 = 8; mdu_res_WD = 32'hDEAD_BEEF;
        settle();
        n_cmp++; if (D_stall !== 1'b1) begin n_bad++; $display("FAIL issue_push_stall: got %0b want 1", D_stall); end
        n_cmp++; if (G_we !== 1'b0) begin n_bad++; $display("FAIL issue_push_we: got %0b want 0", G_we); end
        step();
        mdu_valid = 0;
        settle();
        n_cmp++; if (G_we !== 1'b1) begin n_bad++; $display("FAIL issue_grant_we: got %0b want 1", G_we); end
        n_cmp++; if (G_A3 !== 5'd8) begin n_bad++; $display("FAIL issue_grant_a3: got %0d want 8", G_A3); end
        n_cmp++; if (G_WD !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL issue_grant_wd: got %h want deadbeef", G_WD); end
        n_cmp++; if (D_stall !== 1'b0) begin n_bad++; $display("FAIL issue_bypass_stall: got %0b want 0", D_stall); end
        step();
        D_rt = 8; D_A3 = 8; D_RegWrite = 1;
        settle();
        n_cmp++; if (G_we !== 1'b0) begin n_bad++; $display("FAIL issue_after_we: got %0b want 0", G_we); end
        n_cmp++; if (D_stall !== 1'b0) begin n_bad++; $display("FAIL issue_after_stall: got %0b want 0", D_stall); end
        idle();
        step();
    endtask

    task automatic test_priority();
        idle();
        mdu_issue = 1; mdu_A3 = 9;
        step();
        mdu_issue = 0;
        W_RegWrite = 1; W_A3 = 3; W_WD = 32'h3;
        mdu_valid = 1; mdu_res_A3 = 9; mdu_res_WD = 32'h1234;
        step();
        mdu_valid = 0;
        for (int k = 0; k < SM; k++) begin
            W_A3 = 5'(20 + k); W_WD = 32'(k);
            settle();
            n_cmp++; if (pipe_hold !== 1'b0) begin n_bad++; $display("FAIL prio_hold_%0d: got %0b want 0", k, pipe_hold); end
            n_cmp++; if (G_A3 !== 5'(20 + k)) begin n_bad++; $display("FAIL prio_pipe_a3_%0d: got %0d want %0d", k, G_A3, 20 + k); end
            step();
        end
        settle();
        n_cmp++; if (pipe_hold !== 1'b1) begin n_bad++; $display("FAIL prio_hold_5th: got %0b want 1", pipe_hold); end
        n_cmp++; if (D_stall !== 1'b1) begin n_bad++; $display("FAIL prio_stall_5th: got %0b want 1", D_stall); end
        n_cmp++; if (G_A3 !== 5'd9 || G_WD !== 32'h1234 || G_we !== 1'b1) begin n_bad++; $display("FAIL prio_mdu_5th: got we=%0b a3=%0d wd=%h want 1 9 1234", G_we, G_A3, G_WD); end
        step();
        settle();
        n_cmp++; if (pipe_hold !== 1'b0 || G_A3 !== W_A3) begin n_bad++; $display("FAIL prio_after: got hold=%0b a3=%0d want 0 %0d", pipe_hold, G_A3, W_A3); end
        idle();
        step();
    endtask

    task automatic test_full();
        idle();
        mdu_issue = 1; mdu_A3 = 10;
        step();
        mdu_A3 = 11;
        step();
        mdu_A3 = 12;
        W_RegWrite = 1; W_A3 = 1;
        mdu_valid = 1; mdu_res_A3 = 10; mdu_res_WD = 32'hA;
        settle();
        n_cmp++; if (D_stall !== 1'b1) begin n_bad++; $display("FAIL full_stall_a: got %0b want 1", D_stall); end
        step();
        mdu_res_A3 = 11; mdu_res_WD = 32'hB;
        settle();
        n_cmp++; if (D_stall !== 1'b1 || mdu_ready !== 1'b1) begin n_bad++; $display("FAIL full_b: got stall=%0b ready=%0b want 1 1", D_stall, mdu_ready); end
        step();
        mdu_valid = 0;
        settle();
        n_cmp++; if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0b want 0", mdu_ready); end
        step();
        W_RegWrite = 0;
        settle();
        n_cmp++; if (G_A3 !== 5'd10 || D_stall !== 1'b1) begin n_bad++; $display("FAIL full_pop1: got a3=%0d stall=%0b want 10 1", G_A3, D_stall); end
        step();
        settle();
        n_cmp++; if (G_A3 !== 5'd11 || D_stall !== 1'b0 || mdu_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop2: got a3=%0d stall=%0b ready=%0b want 11 0 1", G_A3, D_stall, mdu_ready); end
        step();
        idle();
    endtask

    task automatic test_waw_zero();
        idle();
        D_RegWrite = 1; D_A3 = 12;
        settle();
        n_cmp++; if (D_stall !== 1'b1) begin n_bad++; $display("FAIL waw_stall: got %0b want 1", D_stall); end
        D_RegWrite = 0; D_A3 = 0;
        #1;
        n_cmp++; if (D_stall !== 1'b0) begin n_bad++; $display("FAIL waw_release: got %0b want 0", D_stall); end
        mdu_issue = 1; mdu_A3 = 0;
        step();
        mdu_issue = 0;
        mdu_valid = 1; mdu_res_A3 = 0; mdu_res_WD = 32'hABCD;
        step();
        mdu_valid = 0; D_rs = 12;
        settle();
        n_cmp++; if (G_we !== 1'b0 || G_A3 !== 5'd0) begin n_bad++; $display("FAIL zero_we: got we=%0b a3=%0d want 0 0", G_we, G_A3); end
        n_cmp++; if (D_stall !== 1'b1) begin n_bad++; $display("FAIL zero_pending12: got %0b want 1", D_stall); end
        step();
        mdu_valid = 1; mdu_res_A3 = 12; mdu_res_WD = 32'hC;
        settle();
        n_cmp++; if (mdu_ready !== 1'b1 || G_we !== 1'b0) begin n_bad++; $display("FAIL zero_popped: got ready=%0b we=%0b want 1 0", mdu_ready, G_we); end
        step();
        mdu_valid = 0;
        settle();
        n_cmp++; if (G_we !== 1'b1 || G_A3 !== 5'd12 || D_stall !== 1'b0) begin n_bad++; $display("FAIL zero_clear12: got we=%0b a3=%0d stall=%0b want 1 12 0", G_we, G_A3, D_stall); end
        step();
        idle();
    endtask

    task automatic test_mid_reset();
        idle();
        mdu_issue = 1; mdu_A3 = 13;
        step();
        mdu_A3 = 14;
        step();
        mdu_issue = 0;
        W_RegWrite = 1; W_A3 = 1;
        mdu_valid = 1; mdu_res_A3 = 13;
        step();
        mdu_res_A3 = 14;
        step();
        mdu_valid = 0;
        settle();
        n_cmp++; if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_before_ready: got %0b want 0", mdu_ready); end
        reset = 0;
        step();
        reset = 1; W_RegWrite = 0; D_rs = 13; D_rt = 14;
        settle();
        n_cmp++; if (G_we !== 1'b0) begin n_bad++; $display("FAIL midrst_we: got %0b want 0", G_we); end
        n_cmp++; if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %0b want 1", mdu_ready); end
        n_cmp++; if (D_stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %0b want 0", D_stall); end
        mdu_issue = 1; mdu_A3 = 15;
        #1;
        n_cmp++; if (D_stall !== 1'b0) begin n_bad++; $display("FAIL midrst_outstanding: got %0b want 0", D_stall); end
        mdu_issue = 0;
        step();
        settle();
        n_cmp++; if (G_we !== 1'b0) begin n_bad++; $display("FAIL midrst_we_later: got %0b want 0", G_we); end
        idle();
    endtask

    task automatic test_random();
        int  src;
        int  e_a3;
        bit  hv, e_hold, e_we, e_stall, e_ready, head_gnt, push, acc;
        logic [31:0] e_wd;
        idle();
        reset = 0;
        step();
        reset = 1;
        q_a3.delete(); q_wd.delete(); inflight.delete();
        pend = '0; outst = 0; starve = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset      = ($urandom_range(0, 299) != 0);
            W_RegWrite = 1'($urandom_range(0, 1));
            W_A3       = 5'($urandom_range(0, 31));
            W_WD       = $urandom;
            mdu_issue  = ($urandom_range(0, 2) == 0);
            mdu_A3     = 5'($urandom_range(0, 15));
            mdu_valid  = (inflight.size() > 0) && ($urandom_range(0, 1) == 1);
            mdu_res_A3 = (inflight.size() > 0) ? 5'(inflight[0]) : 5'd0;
            mdu_res_WD = $urandom;
            D_rs       = 5'($urandom_range(0, 15));
            D_rt       = 5'($urandom_range(0, 15));
            D_A3       = 5'($urandom_range(0, 15));
            D_RegWrite = 1'($urandom_range(0, 1));
            settle();
            if (!reset) begin
                q_a3.delete(); q_wd.delete(); inflight.delete();
                pend = '0; outst = 0; starve = 0;
            end else begin
                hv     = (q_a3.size() > 0);
                e_hold = hv && (starve == SM);
                if (e_hold)          src = 2;
                else if (W_RegWrite) src = 1;
                else if (hv)         src = 2;
                else                 src = 0;
                e_a3 = (src == 1) ? int'(W_A3) : (src == 2) ? q_a3[0] : 0;
                e_wd = (src == 1) ? W_WD : (src == 2) ? q_wd[0] : 32'd0;
                e_we = (src != 0) && (e_a3 != 0);
                head_gnt = (src == 2);
                e_stall = (pend[D_rs] && !(head_gnt && q_a3[0] == int'(D_rs)))
                       || (pend[D_rt] && !(head_gnt && q_a3[0] == int'(D_rt)))
                       || (D_RegWrite && pend[D_A3])
                       || (mdu_issue && outst == DEPTH)
                       || e_hold;
                e_ready = (q_a3.size() < DEPTH);
                n_cmp++; if (mdu_ready !== e_ready) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_ready @%0d: got %0b want %0b", cyc, mdu_ready, e_ready); end
                n_cmp++; if (D_stall !== e_stall) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_stall @%0d: got %0b want %0b", cyc, D_stall, e_stall); end
                n_cmp++; if (pipe_hold !== e_hold) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_hold @%0d: got %0b want %0b", cyc, pipe_hold, e_hold); end
                n_cmp++; if (G_we !== e_we) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_we @%0d: got %0b want %0b", cyc, G_we, e_we); end
                n_cmp++; if (G_A3 !== 5'(e_a3)) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_a3 @%0d: got %0d want %0d", cyc, G_A3, e_a3); end
                n_cmp++; if (G_WD !== e_wd) begin n_bad++; if (n_bad < 20) $display("FAIL rnd_wd @%0d: got %h want %h", cyc, G_WD, e_wd); end
                push = mdu_valid && e_ready;
                acc  = mdu_issue && !e_stall;
                if (!hv || head_gnt)  starve = 0;
                else if (starve < SM) starve++;
                if (head_gnt) begin
                    pend[q_a3[0]] = 1'b0;
                    q_a3.delete(0);
                    q_wd.delete(0);
                    outst--;
                end
                if (acc) begin
                    pend[mdu_A3] = 1'b1;
                    inflight.push_back(int'(mdu_A3));
                    outst++;
                end
                pend[0] = 1'b0;
                if (push) begin
                    q_a3.push_back(int'(mdu_res_A3));
                    q_wd.push_back(mdu_res_WD);
                    inflight.delete(0);
                end
            end
            step();
        end
        reset = 1;
        idle();
    endtask

    initial begin
        reset = 0;
        idle();
        test_reset();
        test_issue_stall();
        test_priority();
        test_full();
        test_waw_zero();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
